// File: rtl/chunk_adder_pkg.sv
// Shared types and defaults for the chunk-serial adder.
// Holds the FSM state encoding and the default operand/chunk widths.
package chunk_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder_if.sv
// Operand/result handshake bundle for chunk_adder.
// The master drives operands and consumes results; the slave is the adder.
interface chunk_adder_if
  import chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );

endinterface

// File: rtl/chunk_adder_rca.sv
// CHUNK-bit ripple-carry adder slice.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_rca #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock over NCHUNK cycles.
// Accepts one operand set in IDLE, ripples through chunks in RUN, holds the result in DONE.
module chunk_adder
  import chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input logic         clk,
  input logic         rst_n,
  chunk_adder_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] s_q, s_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             carry_q, carry_nxt;
  logic             co_q, co_nxt;
  logic             ovf_q, ovf_nxt;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             c_msb;

  assign base = 32'(idx_q) * CHUNK;

  chunk_rca #(.CHUNK(CHUNK)) u_rca (
    .a     (a_q[base +: CHUNK]),
    .b     (b_q[base +: CHUNK]),
    .cin   (carry_q),
    .sum   (sum),
    .cout  (cout),
    .c_msb (c_msb)
  );

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    s_nxt     = s_q;
    idx_nxt   = idx_q;
    carry_nxt = carry_q;
    co_nxt    = co_q;
    ovf_nxt   = ovf_q;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_nxt     = bus.a;
          b_nxt     = bus.sub ? ~bus.b : bus.b;
          carry_nxt = bus.sub | bus.cin;
          idx_nxt   = '0;
          s_nxt     = '0;
          co_nxt    = 1'b0;
          ovf_nxt   = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        s_nxt[base +: CHUNK] = sum;
        carry_nxt            = cout;
        if (idx_q == IDX_LAST) begin
          co_nxt    = cout;
          ovf_nxt   = c_msb ^ cout;
          idx_nxt   = '0;
          state_nxt = DONE;
        end else begin
          idx_nxt = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      a_q         <= a_nxt;
      b_q         <= b_nxt;
      s_q         <= s_nxt;
      idx_q       <= idx_nxt;
      carry_q     <= carry_nxt;
      co_q        <= co_nxt;
      ovf_q       <= ovf_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4: bits added per clock cycle; WIDTH % CHUNK == 0, any other value SHALL be an elaboration error.
REQ-003 Derived constant NCHUNK = WIDTH/CHUNK: cycles per operation.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand set a, b, cin, sub is valid.
REQ-007 in_ready  output  1  block can accept an operand set.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, used only when sub=0.
REQ-011 sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1, cin ignored).
REQ-012 out_valid  output  1  s, co, ovf hold a completed result.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-015 co  output  1  final carry-out; for sub, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-018 IDLE: on edge with in_valid=1, latch a, b (b inverted when sub=1), carry register = sub ? 1 : cin, chunk index = 0, clear s, go RUN; in_valid=0 stays IDLE.
REQ-019 RUN: each edge adds chunk [idx*CHUNK +: CHUNK] of latched A, B plus carry register, writes that chunk of s, updates carry register, increments idx.
REQ-020 RUN: on the edge processing idx = NCHUNK-1, register co and ovf, go DONE; out_valid SHALL rise exactly NCHUNK edges after the accepting edge.
REQ-021 DONE: s, co, ovf held stable while out_ready=0; edge with out_ready=1 goes IDLE, out_valid falls.
REQ-022 in_valid during RUN or DONE SHALL be ignored; operands not latched, no state change.
REQ-023 Input ports a, b, cin, sub SHALL be sampled only on the accepting edge; later changes have no effect on the result.
REQ-024 idx SHALL be ceil(log2(NCHUNK)) bits wide (min 1) and never exceed NCHUNK-1.
REQ-025 CHUNK = WIDTH SHALL work: one RUN cycle, out_valid one edge after accept.
REQ-026 Throughput: one operation per NCHUNK+2 cycles minimum with out_ready held 1.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, s=0, co=0, ovf=0, out_valid=0, in_ready=1 after release, carry register=0, idx=0.
REQ-028 Reset in RUN or DONE SHALL abort the operation; no result is ever presented for it.
REQ-029 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 State encodings for IDLE/RUN/DONE and default WIDTH/CHUNK SHALL live in the shared package/include file.
REQ-031 One combinational sub-module, chunk_rca (CHUNK-bit ripple-carry adder, outputs sum, carry-out and carry into MSB), SHALL be instantiated once.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 edges out_valid=1, s=0x0000, co=1, ovf=0.
REQ-033 a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, co=0, ovf=0; a=0x7FFF, b=0x0001, sub=0, cin=0 -> s=0x8000, ovf=1.
REQ-034 out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands -> s/co/ovf unchanged, in_ready=0, new set not accepted.
REQ-035 rst_n pulsed low during RUN idx=2 -> all outputs 0 immediately, in_ready=1 after release, no out_valid for aborted operation.
REQ-036 WIDTH=16, CHUNK=16: a=0x1234, b=0x4321, cin=1 -> out_valid one edge after accept, s=0x5556, co=0.
REQ-037 Random back-to-back stream of 1000 operands with random out_ready -> every result matches reference model, ordering preserved.
